// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM state encoding and overflow helpers for the
// multicycle ALU and its benches.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_MUL = 4'b0011,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_SLL = 4'b1000,
    OP_SRL = 4'b1001,
    OP_SRA = 4'b1010,
    OP_NOR = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_e;

  // Signed overflow from sign bits of x, y and the result.
  function automatic logic add_ovf(input logic xs, input logic ys, input logic rs);
    return (xs == ys) && (rs != xs);
  endfunction

  function automatic logic sub_ovf(input logic xs, input logic ys, input logic rs);
    return (xs != ys) && (rs != xs);
  endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Operand/result handshake bundle between an ALU client (master) and the ALU (slave).
interface alu_multicycle_if #(
  parameter int WIDTH = 64
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic [3:0]       aluControl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;

  modport master (
    output in_valid, x, y, aluControl, out_ready,
    input  in_ready, out_valid, result, zero, overflow
  );

  modport slave (
    input  in_valid, x, y, aluControl, out_ready,
    output in_ready, out_valid, result, zero, overflow
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, exactly WIDTH
// cycles after start, low WIDTH bits of the unsigned product.
module alu_mul_iter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_r;
  logic [WIDTH-1:0] mplier_r;
  logic [WIDTH-1:0] acc_r;
  logic [CW-1:0]    cnt_r;
  logic             busy_r;
  logic [WIDTH-1:0] addend_s;

  // Next accumulator value; on the last step this is the final product,
  // so the consumer can register it on the same edge that ends the run.
  always_comb begin
    addend_s = mplier_r[0] ? mcand_r : {WIDTH{1'b0}};
    product  = acc_r + addend_s;
    done     = busy_r && (cnt_r == CW'(WIDTH - 1));
  end

  // Operand shift registers, accumulator and step counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_r  <= {WIDTH{1'b0}};
      mplier_r <= {WIDTH{1'b0}};
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b0;
    end else if (start) begin
      mcand_r  <= a;
      mplier_r <= b;
      acc_r    <= {WIDTH{1'b0}};
      cnt_r    <= {CW{1'b0}};
      busy_r   <= 1'b1;
    end else if (busy_r) begin
      acc_r    <= product;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      cnt_r    <= cnt_r + CW'(1);
      busy_r   <= !done;
    end
  end
endmodule

// File: rtl/alu_multicycle.sv
// Handshaked ALU: single-cycle logic/arith/shift ops, iterative multiply,
// result held in DONE until the consumer takes it.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst,
  alu_multicycle_if.slave bus
);
  alu_state_e       state_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic             overflow_r;

  logic             accept_s;
  logic             is_mul_s;
  logic             mul_done_s;
  logic [WIDTH-1:0] mul_product_s;
  logic [WIDTH-1:0] sum_s;
  logic [WIDTH-1:0] diff_s;
  logic [SHW-1:0]   shamt_s;
  logic [WIDTH-1:0] alu_result_s;
  logic             alu_ovf_s;

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.result    = result_r;
  assign bus.zero      = zero_r;
  assign bus.overflow  = overflow_r;

  // in_ready_r is high exactly in IDLE, so it doubles as the state qualifier.
  assign accept_s = bus.in_valid && in_ready_r;
  assign is_mul_s = (bus.aluControl == OP_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept_s && is_mul_s),
    .a       (bus.x),
    .b       (bus.y),
    .done    (mul_done_s),
    .product (mul_product_s)
  );

  // Single-cycle operations, evaluated on the operands presented at accept.
  always_comb begin
    sum_s        = bus.x + bus.y;
    diff_s       = bus.x - bus.y;
    shamt_s      = bus.y[SHW-1:0];
    alu_result_s = {WIDTH{1'b0}};
    alu_ovf_s    = 1'b0;
    case (bus.aluControl)
      OP_AND: alu_result_s = bus.x & bus.y;
      OP_OR:  alu_result_s = bus.x | bus.y;
      OP_NOR: alu_result_s = ~(bus.x | bus.y);
      OP_ADD: begin
        alu_result_s = sum_s;
        alu_ovf_s    = add_ovf(bus.x[WIDTH-1], bus.y[WIDTH-1], sum_s[WIDTH-1]);
      end
      OP_SUB: begin
        alu_result_s = diff_s;
        alu_ovf_s    = sub_ovf(bus.x[WIDTH-1], bus.y[WIDTH-1], diff_s[WIDTH-1]);
      end
      OP_SLT: begin
        if ($signed(bus.x) < $signed(bus.y)) begin
          alu_result_s = {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
          alu_result_s = {WIDTH{1'b0}};
        end
      end
      OP_SLL: alu_result_s = bus.x << shamt_s;
      OP_SRL: alu_result_s = bus.x >> shamt_s;
      OP_SRA: alu_result_s = WIDTH'($signed(bus.x) >>> shamt_s);
      default: begin
        alu_result_s = {WIDTH{1'b0}};
        alu_ovf_s    = 1'b0;
      end
    endcase
  end

  // Control FSM with registered handshake flags and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
      zero_r      <= 1'b1;
      overflow_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            in_ready_r <= 1'b0;
            if (is_mul_s) begin
              state_r <= ST_MUL;
            end else begin
              state_r     <= ST_DONE;
              out_valid_r <= 1'b1;
              result_r    <= alu_result_s;
              zero_r      <= (alu_result_s == {WIDTH{1'b0}});
              overflow_r  <= alu_ovf_s;
            end
          end
        end
        ST_MUL: begin
          if (mul_done_s) begin
            state_r     <= ST_DONE;
            out_valid_r <= 1'b1;
            result_r    <= mul_product_s;
            zero_r      <= (mul_product_s == {WIDTH{1'b0}});
            overflow_r  <= 1'b0;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_r     <= ST_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule
